// File: rtl/dragon_pkg.sv
// Shared widths, direction codes and the {pos, dir} history entry type
// for the dragon body history buffer.
package dragon_pkg;

  localparam int unsigned POS_W = 8;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned LEN_W = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b11;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [DIR_W-1:0] dir;
  } seg_t;

endpackage

// File: rtl/dragon_segment_reg.sv
// One stage of the body history buffer: loads the previous stage's
// {pos, dir} when the head moves, otherwise holds.
module dragon_segment_reg
  import dragon_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift,
  input  seg_t prev,
  output seg_t seg
);

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= '0;
    end else if (shift) begin
      seg <= prev;
    end
  end

endmodule

// File: rtl/dragon_body.sv
// Trailing body of the dragon: history buffer of past head positions,
// body length bookkeeping (grow/shrink) and head-on-body detection.
module dragon_body
  import dragon_pkg::*;
#(
  parameter int unsigned MAX_SEGMENTS = 8,
  parameter int unsigned INIT_LENGTH  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vsync,
  input  logic [POS_W-1:0]                head_pos,
  input  logic [DIR_W-1:0]                head_dir,
  input  logic                            grow,
  input  logic                            shrink,
  output logic [POS_W*MAX_SEGMENTS-1:0]   segment_pos,
  output logic [DIR_W*MAX_SEGMENTS-1:0]   segment_dir,
  output logic [MAX_SEGMENTS-1:0]         segment_active,
  output logic [LEN_W-1:0]                body_length,
  output logic                            self_hit
);

  localparam logic [LEN_W-1:0]        MAX_LEN   = LEN_W'(MAX_SEGMENTS);
  localparam logic [LEN_W-1:0]        INIT_LEN  = LEN_W'(INIT_LENGTH);
  localparam logic [MAX_SEGMENTS-1:0] INIT_MASK =
    MAX_SEGMENTS'((32'd1 << INIT_LENGTH) - 32'd1);

  logic             vsync_q;
  logic [POS_W-1:0] last_pos;
  logic [DIR_W-1:0] last_dir;
  logic [1:0]       grow_pend;
  logic             shrink_pend;

  logic                    tick_c;
  logic                    move_c;
  logic                    match_c;
  logic                    grow_req_c;
  logic                    shrink_req_c;
  logic                    grow_apply_c;
  logic                    shrink_apply_c;
  logic [1:0]              pend_dec_c;
  logic [1:0]              grow_pend_next_c;
  logic                    shrink_pend_next_c;
  logic [LEN_W-1:0]        length_next_c;
  logic [MAX_SEGMENTS-1:0] active_next_c;

  seg_t seg_q [MAX_SEGMENTS];

  assign tick_c = vsync & ~vsync_q;
  assign move_c = tick_c && (head_pos != last_pos);

  // History chain: stage 0 takes the head's previous position, stage i the stage before it.
  for (genvar i = 0; i < int'(MAX_SEGMENTS); i++) begin : g_seg
    seg_t prev_c;
    if (i == 0) begin : g_head
      assign prev_c = '{pos: last_pos, dir: last_dir};
    end else begin : g_link
      assign prev_c = seg_q[i-1];
    end

    dragon_segment_reg u_seg (
      .clk   (clk),
      .reset (reset),
      .shift (move_c),
      .prev  (prev_c),
      .seg   (seg_q[i])
    );

    assign segment_pos[i*POS_W +: POS_W] = seg_q[i].pos;
    assign segment_dir[i*DIR_W +: DIR_W] = seg_q[i].dir;
  end

  // Head against every active segment, pre-shift buffer.
  always_comb begin
    match_c = 1'b0;
    for (int i = 0; i < int'(MAX_SEGMENTS); i++) begin
      if (segment_active[i] && (seg_q[i].pos == head_pos)) begin
        match_c = 1'b1;
      end
    end
  end

  // Length and pending-event control; a grow/shrink collision cancels both requests.
  always_comb begin
    grow_req_c     = grow & ~shrink;
    shrink_req_c   = shrink & ~grow;
    grow_apply_c   = move_c && (grow_pend != 2'd0) && (body_length < MAX_LEN);
    shrink_apply_c = tick_c && shrink_pend && (body_length > LEN_W'(1));

    pend_dec_c       = grow_apply_c ? (grow_pend - 2'd1) : grow_pend;
    grow_pend_next_c = (grow_req_c && (pend_dec_c != 2'd3)) ? (pend_dec_c + 2'd1) : pend_dec_c;

    if (shrink_req_c) begin
      shrink_pend_next_c = 1'b1;
    end else if (tick_c) begin
      shrink_pend_next_c = 1'b0;
    end else begin
      shrink_pend_next_c = shrink_pend;
    end

    length_next_c = body_length;
    active_next_c = segment_active;
    if (grow_apply_c && !shrink_apply_c) begin
      length_next_c = body_length + LEN_W'(1);
      active_next_c = {segment_active[MAX_SEGMENTS-2:0], 1'b1};
    end else if (shrink_apply_c && !grow_apply_c) begin
      length_next_c = body_length - LEN_W'(1);
      active_next_c = segment_active >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q        <= 1'b0;
      last_pos       <= '0;
      last_dir       <= '0;
      grow_pend      <= 2'd0;
      shrink_pend    <= 1'b0;
      body_length    <= INIT_LEN;
      segment_active <= INIT_MASK;
      self_hit       <= 1'b0;
    end else begin
      vsync_q        <= vsync;
      grow_pend      <= grow_pend_next_c;
      shrink_pend    <= shrink_pend_next_c;
      body_length    <= length_next_c;
      segment_active <= active_next_c;
      if (move_c) begin
        last_pos <= head_pos;
        last_dir <= head_dir;
      end
      // A head sitting still is on its own previous cell, which never counts as a hit.
      if (tick_c) begin
        self_hit <= (head_pos != last_pos) && match_c;
      end
    end
  end

endmodule

// File: tb/tb_dragon_body.sv
// Directed bench for dragon_body with hand-computed expectations.
module tb_dragon_body;
  import dragon_pkg::*;

  localparam int unsigned MAX = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 vsync;
  logic [POS_W-1:0]     head_pos;
  logic [DIR_W-1:0]     head_dir;
  logic                 grow;
  logic                 shrink;
  logic [POS_W*MAX-1:0] segment_pos;
  logic [DIR_W*MAX-1:0] segment_dir;
  logic [MAX-1:0]       segment_active;
  logic [LEN_W-1:0]     body_length;
  logic                 self_hit;

  int checks = 0;
  int errors = 0;

  dragon_body #(.MAX_SEGMENTS(MAX), .INIT_LENGTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .vsync          (vsync),
    .head_pos       (head_pos),
    .head_dir       (head_dir),
    .grow           (grow),
    .shrink         (shrink),
    .segment_pos    (segment_pos),
    .segment_dir    (segment_dir),
    .segment_active (segment_active),
    .body_length    (body_length),
    .self_hit       (self_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic g, input logic s);
    grow = g;
    shrink = s;
    @(negedge clk);
    grow = 1'b0;
    shrink = 1'b0;
  endtask

  // One frame: vsync high for a single cycle (the tick), then low for one.
  task automatic frame(input logic [POS_W-1:0] pos, input logic [DIR_W-1:0] dir,
                       input logic g = 1'b0, input logic s = 1'b0);
    head_pos = pos;
    head_dir = dir;
    grow = g;
    shrink = s;
    vsync = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    shrink = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_len [7];
    exp_len = '{3, 4, 5, 5, 5, 5, 5};
    reset = 1'b1;
    vsync = 1'b0;
    head_pos = '0;
    head_dir = '0;
    grow = 1'b0;
    shrink = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst_len", 64'(body_length), 64'd2);
    check("rst_active", 64'(segment_active), 64'h03);
    check("rst_hit", 64'(self_hit), 64'd0);
    check("rst_pos", 64'(segment_pos), 64'h0);

    // Stationary head: no shift, no hit
    repeat (3) frame(8'h00, DIR_RIGHT);
    check("still_len", 64'(body_length), 64'd2);
    check("still_active", 64'(segment_active), 64'h03);
    check("still_hit", 64'(self_hit), 64'd0);
    check("still_pos", 64'(segment_pos), 64'h0);

    // Moves: last_dir only latches on a move, so the 00 entry keeps dir 00
    frame(8'h10, DIR_RIGHT);
    frame(8'h20, DIR_RIGHT);
    check("mv_seg0_pos", 64'(segment_pos[7:0]), 64'h10);
    check("mv_seg0_dir", 64'(segment_dir[1:0]), 64'(DIR_RIGHT));
    check("mv_seg1_pos", 64'(segment_pos[15:8]), 64'h00);
    check("mv_seg1_dir", 64'(segment_dir[3:2]), 64'(DIR_UP));
    check("mv_len", 64'(body_length), 64'd2);

    // Grow waits for a moving tick
    pulse(1'b1, 1'b0);
    frame(8'h20, DIR_RIGHT);
    check("grow_nomove_len", 64'(body_length), 64'd2);
    frame(8'h30, DIR_RIGHT);
    check("grow_len", 64'(body_length), 64'd3);
    check("grow_active", 64'(segment_active), 64'h07);
    check("grow_seg1", 64'(segment_pos[15:8]), 64'h10);
    check("grow_seg2", 64'(segment_pos[23:16]), 64'h00);

    // vsync held high: only its rising edge ticks
    head_pos = 8'h40;
    head_dir = DIR_DOWN;
    vsync = 1'b1;
    @(negedge clk);
    head_pos = 8'h50;
    head_dir = DIR_LEFT;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    check("long_seg0_pos", 64'(segment_pos[7:0]), 64'h30);
    check("long_seg1_pos", 64'(segment_pos[15:8]), 64'h20);
    frame(8'h40, DIR_DOWN);
    check("long_hold_seg0", 64'(segment_pos[7:0]), 64'h30);
    frame(8'h50, DIR_LEFT);
    check("long_seg0_new", 64'(segment_pos[7:0]), 64'h40);
    check("long_seg0_dir", 64'(segment_dir[1:0]), 64'(DIR_DOWN));

    // Grow on the tick cycle itself applies on the following tick
    frame(8'h60, DIR_LEFT, 1'b1, 1'b0);
    check("tickgrow_len0", 64'(body_length), 64'd3);
    frame(8'h70, DIR_LEFT);
    check("tickgrow_len1", 64'(body_length), 64'd4);
    check("tickgrow_active", 64'(segment_active), 64'h0F);

    // Saturating grow_pend and the MAX_SEGMENTS ceiling
    do_reset();
    repeat (10) pulse(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      frame(8'(i + 1), DIR_RIGHT);
      check("sat_len", 64'(body_length), 64'(exp_len[i]));
    end
    repeat (3) pulse(1'b1, 1'b0);
    frame(8'h08, DIR_RIGHT);
    frame(8'h09, DIR_RIGHT);
    frame(8'h0A, DIR_RIGHT);
    check("max_len", 64'(body_length), 64'd8);
    check("max_active", 64'(segment_active), 64'hFF);
    pulse(1'b1, 1'b0);
    frame(8'h0B, DIR_RIGHT);
    check("max_hold_len", 64'(body_length), 64'd8);
    check("max_hold_active", 64'(segment_active), 64'hFF);
    pulse(1'b0, 1'b1);
    frame(8'h0C, DIR_RIGHT);
    check("max_shrink_len", 64'(body_length), 64'd7);
    check("max_shrink_active", 64'(segment_active), 64'h7F);
    frame(8'h0D, DIR_RIGHT);
    check("held_grow_len", 64'(body_length), 64'd8);

    // Grow and shrink applying on the same tick cancel
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    frame(8'h05, DIR_UP);
    check("both_len", 64'(body_length), 64'd2);
    check("both_active", 64'(segment_active), 64'h03);
    frame(8'h06, DIR_UP);
    check("both_after_len", 64'(body_length), 64'd2);

    // Shrink floor at length 1; simultaneous grow+shrink pulses are dropped
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1);
      frame(8'h00, DIR_UP);
      check("shrink_len", 64'(body_length), 64'd1);
    end
    check("shrink_active", 64'(segment_active), 64'h01);
    pulse(1'b1, 1'b1);
    frame(8'h01, DIR_UP);
    check("gs_len", 64'(body_length), 64'd1);
    frame(8'h02, DIR_UP);
    check("gs_after_len", 64'(body_length), 64'd1);

    // Self collision along a closed loop
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    frame(8'h11, DIR_RIGHT);
    frame(8'h12, DIR_UP);
    check("loop_len", 64'(body_length), 64'd4);
    frame(8'h22, DIR_RIGHT);
    frame(8'h21, DIR_DOWN);
    check("loop_hit_pre", 64'(self_hit), 64'd0);
    frame(8'h11, DIR_LEFT);
    check("loop_hit", 64'(self_hit), 64'd1);
    frame(8'h33, DIR_RIGHT);
    check("loop_clear", 64'(self_hit), 64'd0);
    frame(8'h12, DIR_UP);
    check("loop_hit_again", 64'(self_hit), 64'd1);

    // Reset arriving mid-frame with vsync high and a grow pending
    reset = 1'b1;
    vsync = 1'b1;
    head_pos = 8'h44;
    grow = 1'b1;
    @(negedge clk);
    check("mid_rst_pos", 64'(segment_pos), 64'h0);
    check("mid_rst_dir", 64'(segment_dir), 64'h0);
    check("mid_rst_active", 64'(segment_active), 64'h03);
    check("mid_rst_len", 64'(body_length), 64'd2);
    check("mid_rst_hit", 64'(self_hit), 64'd0);
    reset = 1'b0;
    vsync = 1'b0;
    grow = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
